dac_bus_rx: RTL and testbench
=============================

DAC_BUS_RX -- requirements
Module: dac_bus_rx

Interface
REQ-001 Parameter WIDTH, default 16: data bus and per-channel word width in bits.
REQ-002 Parameter LOCK_COUNT, default 8: consecutive valid DCI toggles required to declare lock; legal range 2..255.
REQ-003 clk_in  input  1  system clock, 100 MHz nominal; all logic on rising edge.
REQ-004 rst_in  input  1  reset, asynchronous assert, active-low.
REQ-005 D_in  input  WIDTH  time-multiplexed DAC data bus, one word per clk_in cycle.
REQ-006 DCI_in  input  1  data-clock indicator: 1 = DAC0 word on D_in, 0 = DAC1 word on D_in.
REQ-007 clr_err_in  input  1  synchronous clear of err_cnt_out, one-cycle pulse.
REQ-008 DAC0_out  output  WIDTH  recovered channel-0 word.
REQ-009 DAC1_out  output  WIDTH  recovered channel-1 word.
REQ-010 valid_out  output  1  one-cycle strobe: DAC0_out/DAC1_out hold a new coherent pair.
REQ-011 locked_out  output  1  1 while the FSM is in LOCKED.
REQ-012 err_cnt_out  output  16  saturating count of lock losses.

Function
REQ-013 D_in and DCI_in SHALL be registered once on entry (stage S1) before any decision logic.
REQ-014 A toggle SHALL be a cycle where registered DCI differs from its previous registered value; a miss SHALL be a cycle where it does not.
REQ-015 FSM states SHALL be SEARCH, ALIGN, LOCKED; reset state SEARCH.
REQ-016 SEARCH: on a toggle go to ALIGN with toggle counter = 1; on a miss stay.
REQ-017 ALIGN: each toggle increments the counter; on reaching LOCK_COUNT go to LOCKED; a miss returns to SEARCH with counter = 0 and no error increment.
REQ-018 LOCKED: S1 word with DCI=1 latches into a DAC0 holding register; the next S1 word with DCI=0 latches into DAC1_out while the holding register copies to DAC0_out in the same edge.
REQ-019 valid_out SHALL assert exactly the cycle DAC0_out/DAC1_out update; latency 2 clk_in cycles from the DAC1 word on D_in to valid_out.
REQ-020 A DCI=0 word in LOCKED with no preceding DCI=1 word since entering LOCKED SHALL be discarded without valid_out.
REQ-021 A miss in LOCKED SHALL drop to SEARCH the next cycle, deassert locked_out, suppress valid_out for the incomplete pair, and increment err_cnt_out.
REQ-022 err_cnt_out SHALL saturate at 16'hFFFF and not wrap.
REQ-023 clr_err_in coincident with an increment: clear wins, result 0.
REQ-024 DAC0_out/DAC1_out SHALL hold their last value while valid_out is low, including after lock loss.

Reset
REQ-025 rst_in low SHALL asynchronously force: FSM SEARCH, counter 0, S1 registers 0, DAC0_out 0, DAC1_out 0, valid_out 0, locked_out 0, err_cnt_out 0.
REQ-026 Reset asserted mid-pair SHALL discard the holding register; after release, lock re-acquires from SEARCH.

Configuration
REQ-027 Macro DAC_BUS_RX_ERRCNT_EN defined: err_cnt_out and clr_err_in behave per REQ-021..023.
REQ-028 Macro undefined: no counter logic; err_cnt_out tied 0; clr_err_in ignored; all other behaviour unchanged.

Structure
REQ-029 Package dac_bus_pkg SHALL hold the FSM state typedef, default WIDTH, default LOCK_COUNT, and the error counter width constant (16).
REQ-030 Sub-module dac_bus_rx_lock_fsm SHALL contain the toggle detector, toggle counter, and FSM, exporting state and toggle/miss flags; the datapath stays in dac_bus_rx.

Verification
REQ-031 Reset release, DCI alternating 1,0 from cycle 0, D_in = 16'hFFFF on DCI=1 and 16'h5555 on DCI=0 -> locked_out high after 8 toggles; first valid_out shows DAC0_out=FFFF, DAC1_out=5555; valid_out every 2nd cycle thereafter.
REQ-032 Locked stream, DCI held 1 for two cycles -> locked_out low next cycle, no valid_out for the broken pair, err_cnt_out=1, re-lock after 8 further toggles.
REQ-033 Lock entered on a DCI=0 phase -> first DCI=0 word discarded; first valid_out carries a DCI=1/DCI=0 ordered pair.
REQ-034 err_cnt_out preloaded via 65535 forced losses -> one more loss leaves FFFF; clr_err_in pulsed in the same cycle as a loss -> 0.
REQ-035 rst_in pulsed low for 1 ns mid-pair -> all outputs 0 immediately, no valid_out until re-lock.
REQ-036 Build without DAC_BUS_RX_ERRCNT_EN, repeat REQ-032 -> identical lock/valid behaviour, err_cnt_out stays 0.

Source files
------------

// File: rtl/dac_bus_pkg.sv
// Shared types and defaults for the DAC bus receiver.
`timescale 1ns/1ps
package dac_bus_pkg;
  localparam int DEF_WIDTH      = 16;
  localparam int DEF_LOCK_COUNT = 8;
  localparam int ERR_CNT_W      = 16;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_LOCKED = 2'd2
  } lock_state_t;
endpackage

// File: rtl/dac_bus_rx_lock_fsm.sv
// DCI toggle detector, toggle counter and SEARCH/ALIGN/LOCKED state machine.
`timescale 1ns/1ps
module dac_bus_rx_lock_fsm
  import dac_bus_pkg::*;
#(
  parameter int LOCK_COUNT = DEF_LOCK_COUNT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_dci,
  output lock_state_t o_state,
  output logic        o_toggle,
  output logic        o_miss
);
  localparam logic [7:0] LC_LAST = 8'(LOCK_COUNT - 1);

  lock_state_t r_state;
  logic [7:0]  r_cnt;
  logic        r_dci_prev;
  logic        w_toggle;

  assign w_toggle = i_dci ^ r_dci_prev;
  assign o_toggle = w_toggle;
  assign o_miss   = ~w_toggle;
  assign o_state  = r_state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_SEARCH;
      r_cnt      <= '0;
      r_dci_prev <= 1'b0;
    end else begin
      r_dci_prev <= i_dci;
      case (r_state)
        ST_SEARCH: begin
          if (w_toggle) begin
            r_state <= ST_ALIGN;
            r_cnt   <= 8'd1;
          end
        end
        ST_ALIGN: begin
          if (!w_toggle) begin
            r_state <= ST_SEARCH;
            r_cnt   <= '0;
          end else if (r_cnt == LC_LAST) begin
            r_state <= ST_LOCKED;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_LOCKED: begin
          // Any missed toggle means the word pairing can no longer be trusted.
          if (!w_toggle) begin
            r_state <= ST_SEARCH;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= ST_SEARCH;
          r_cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// File: rtl/dac_bus_rx.sv
// Demultiplexes a DCI-tagged DAC bus into channel 0/1 word pairs once DCI is locked.
// Define DAC_BUS_RX_ERRCNT_EN to build the lock-loss counter; otherwise err_cnt_out is 0.
`timescale 1ns/1ps
module dac_bus_rx
  import dac_bus_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [WIDTH-1:0]     D_in,
  input  logic                 DCI_in,
  input  logic                 clr_err_in,
  output logic [WIDTH-1:0]     DAC0_out,
  output logic [WIDTH-1:0]     DAC1_out,
  output logic                 valid_out,
  output logic                 locked_out,
  output logic [ERR_CNT_W-1:0] err_cnt_out
);
  logic [WIDTH-1:0] r_d;
  logic             r_dci;
  logic [WIDTH-1:0] r_hold;
  logic             r_have0;
  logic [WIDTH-1:0] r_dac0;
  logic [WIDTH-1:0] r_dac1;
  logic             r_valid;
  lock_state_t      w_state;
  logic             w_toggle;
  logic             w_miss;
  logic             w_locked;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_d   <= '0;
      r_dci <= 1'b0;
    end else begin
      r_d   <= D_in;
      r_dci <= DCI_in;
    end
  end

  dac_bus_rx_lock_fsm #(.LOCK_COUNT(LOCK_COUNT)) u_lock_fsm (
    .i_clk    (clk_in),
    .i_rst_n  (rst_in),
    .i_dci    (r_dci),
    .o_state  (w_state),
    .o_toggle (w_toggle),
    .o_miss   (w_miss)
  );

  assign w_locked = (w_state == ST_LOCKED);

  // r_have0 marks a captured channel-0 word awaiting its channel-1 partner.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_hold  <= '0;
      r_have0 <= 1'b0;
      r_dac0  <= '0;
      r_dac1  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_locked && w_toggle) begin
        if (r_dci) begin
          r_hold  <= r_d;
          r_have0 <= 1'b1;
        end else if (r_have0) begin
          r_dac0  <= r_hold;
          r_dac1  <= r_d;
          r_valid <= 1'b1;
          r_have0 <= 1'b0;
        end
      end else begin
        r_have0 <= 1'b0;
      end
    end
  end

  assign DAC0_out   = r_dac0;
  assign DAC1_out   = r_dac1;
  assign valid_out  = r_valid;
  assign locked_out = w_locked;

`ifdef DAC_BUS_RX_ERRCNT_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_err_cnt <= '0;
    end else if (clr_err_in) begin
      r_err_cnt <= '0;
    end else if (w_locked && w_miss && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign err_cnt_out = r_err_cnt;
`else
  logic w_unused;
  assign w_unused    = &{1'b0, clr_err_in, w_miss};
  assign err_cnt_out = '0;
`endif
endmodule

// File: tb/tb_dac_bus_rx.sv
// Directed bench for dac_bus_rx: lock, pairing, lock loss, error counter, async reset.
`timescale 1ns/1ps
module tb_dac_bus_rx;
  localparam int W = 16;
`ifdef DAC_BUS_RX_ERRCNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic [W-1:0]  D_in = '0;
  logic          DCI_in = 1'b0;
  logic          clr_err_in = 1'b0;
  logic [W-1:0]  DAC0_out, DAC1_out;
  logic          valid_out, locked_out;
  logic [15:0]   err_cnt_out;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic          last_dci = 1'b0;
  logic [W-1:0]  hist [3];

  always #5 clk_in = ~clk_in;

  dac_bus_rx #(.WIDTH(W), .LOCK_COUNT(8)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .D_in        (D_in),
    .DCI_in      (DCI_in),
    .clr_err_in  (clr_err_in),
    .DAC0_out    (DAC0_out),
    .DAC1_out    (DAC1_out),
    .valid_out   (valid_out),
    .locked_out  (locked_out),
    .err_cnt_out (err_cnt_out)
  );

  // One bus word per cycle; outputs are sampled 1 ns after the edge.
  task automatic step(input logic dci, input logic [W-1:0] d);
    DCI_in   = dci;
    D_in     = d;
    last_dci = dci;
    hist[2]  = hist[1];
    hist[1]  = hist[0];
    hist[0]  = d;
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [W-1:0] dw(input int w);
    if (w < 10) return (w % 2 == 0) ? 16'hFFFF : 16'h5555;
    return 16'(w * 257);
  endfunction

  task automatic lose_once(input logic clr, output bit ok);
    for (int k = 0; k < 24 && !locked_out; k++) step(~last_dci, 16'(16'h4000 + k));
    ok = locked_out;
    step(last_dci, 16'h4444);
    clr_err_in = clr;
    step(~last_dci, 16'h4555);
    clr_err_in = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    n_tests++;
    if ({DAC0_out, DAC1_out, valid_out, locked_out, err_cnt_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h/%h v%b l%b e%h exp all zero",
               DAC0_out, DAC1_out, valid_out, locked_out, err_cnt_out);
    end
    rst_in = 1'b1;
  endtask

  task automatic test_lock;
    logic [2*W-1:0] exp_pair;
    for (int w = 0; w < 16; w++) begin
      step(w % 2 == 0, dw(w));
      n_tests++;
      if (locked_out !== (w >= 8)) begin
        n_fail++;
        $display("FAIL lock_locked w=%0d got %b exp %b", w, locked_out, (w >= 8));
      end
      n_tests++;
      if (valid_out !== (w >= 10 && w % 2 == 0)) begin
        n_fail++;
        $display("FAIL lock_valid w=%0d got %b exp %b", w, valid_out, (w >= 10 && w % 2 == 0));
      end
      if (w < 10)          exp_pair = '0;
      else if (w % 2 == 0) exp_pair = {dw(w - 2), dw(w - 1)};
      else                 exp_pair = {dw(w - 3), dw(w - 2)};
      if (w == 10) exp_pair = {16'hFFFF, 16'h5555};
      n_tests++;
      if ({DAC0_out, DAC1_out} !== exp_pair) begin
        n_fail++;
        $display("FAIL lock_data w=%0d got %h exp %h", w, {DAC0_out, DAC1_out}, exp_pair);
      end
    end
  endtask

  task automatic test_loss_relock;
    logic [2*W-1:0] exp_pair;
    step(1'b1, 16'h1111);
    n_tests++;
    if ({valid_out, locked_out, DAC0_out, DAC1_out} !== {2'b11, 16'h0E0E, 16'h0F0F}) begin
      n_fail++;
      $display("FAIL loss_last_pair got v%b l%b %h/%h exp v1 l1 0e0e/0f0f",
               valid_out, locked_out, DAC0_out, DAC1_out);
    end
    step(1'b1, 16'h2222);
    n_tests++;
    if ({valid_out, locked_out} !== 2'b01) begin
      n_fail++;
      $display("FAIL loss_hold1 got v%b l%b exp v0 l1", valid_out, locked_out);
    end
    step(1'b0, 16'h3012);
    n_tests++;
    if ({valid_out, locked_out, DAC0_out, DAC1_out} !== {2'b00, 16'h0E0E, 16'h0F0F}) begin
      n_fail++;
      $display("FAIL loss_drop got v%b l%b %h/%h exp v0 l0 0e0e/0f0f",
               valid_out, locked_out, DAC0_out, DAC1_out);
    end
    n_tests++;
    if (err_cnt_out !== (ERR_EN ? 16'd1 : 16'd0)) begin
      n_fail++;
      $display("FAIL loss_errcnt got %h exp %h", err_cnt_out, (ERR_EN ? 16'd1 : 16'd0));
    end
    // Re-lock lands on a DCI=1 word, so the first DCI=0 word (w=26) is dropped.
    for (int w = 19; w < 30; w++) begin
      step(w % 2 == 1, 16'(16'h3000 + w));
      n_tests++;
      if ({locked_out, valid_out} !== {(w >= 26), (w == 29)}) begin
        n_fail++;
        $display("FAIL relock_flags w=%0d got l%b v%b exp l%b v%b",
                 w, locked_out, valid_out, (w >= 26), (w == 29));
      end
      exp_pair = (w == 29) ? {16'h301B, 16'h301C} : {16'h0E0E, 16'h0F0F};
      n_tests++;
      if ({DAC0_out, DAC1_out} !== exp_pair) begin
        n_fail++;
        $display("FAIL relock_data w=%0d got %h exp %h", w, {DAC0_out, DAC1_out}, exp_pair);
      end
    end
  endtask

  task automatic test_err_sat;
    bit ok;
    logic [15:0] exp_e;
`ifdef DAC_BUS_RX_ERRCNT_EN
    force dut.r_err_cnt = 16'hFFFE;
    #1;
    release dut.r_err_cnt;
`endif
    for (int i = 0; i < 3; i++) begin
      lose_once(i == 2, ok);
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL err_lock_timeout i=%0d got unlocked exp locked", i);
      end
      exp_e = (ERR_EN && i < 2) ? 16'hFFFF : 16'h0000;
      n_tests++;
      if ({locked_out, err_cnt_out} !== {1'b0, exp_e}) begin
        n_fail++;
        $display("FAIL err_sat i=%0d got l%b e%h exp l0 e%h", i, locked_out, err_cnt_out, exp_e);
      end
    end
  endtask

  task automatic test_reset_mid_pair;
    int n;
    for (int k = 0; k < 30 && !locked_out; k++) step(~last_dci, 16'(16'h6000 + k));
    for (int k = 0; k < 10 && !valid_out; k++) step(~last_dci, 16'(16'h6100 + k));
    n_tests++;
    if (valid_out !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_prepair got v%b exp 1", valid_out);
    end
    step(~last_dci, 16'h6200);
    #2 rst_in = 1'b0;
    #1;
    n_tests++;
    if ({DAC0_out, DAC1_out, valid_out, locked_out, err_cnt_out} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_zero got %h/%h v%b l%b e%h exp all zero",
               DAC0_out, DAC1_out, valid_out, locked_out, err_cnt_out);
    end
    rst_in = 1'b1;
    n = 0;
    while (!locked_out && n < 30) begin
      step(~last_dci, 16'(16'h6300 + n));
      n++;
      n_tests++;
      if (valid_out !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_novalid n=%0d got %b exp 0", n, valid_out);
      end
    end
    n_tests++;
    if (n !== 9) begin
      n_fail++;
      $display("FAIL rstmid_relock_cycles got %0d exp 9", n);
    end
    for (int k = 0; k < 6 && !valid_out; k++) step(~last_dci, 16'(16'h6400 + k));
    n_tests++;
    if ({valid_out, DAC0_out, DAC1_out} !== {1'b1, hist[2], hist[1]}) begin
      n_fail++;
      $display("FAIL rstmid_first_pair got v%b %h/%h exp v1 %h/%h",
               valid_out, DAC0_out, DAC1_out, hist[2], hist[1]);
    end
  endtask

  initial begin
    hist[0] = '0; hist[1] = '0; hist[2] = '0;
    test_reset;
    test_lock;
    test_loss_relock;
    test_err_sat;
    test_reset_mid_pair;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
